// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full_sub cell is reused LSB first to compute a - b over WIDTH cycles.
// Latency: WIDTH+1 cycles from accepted start to the done pulse; a new start can be accepted every WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests made while busy are dropped and never queued.

module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bin;
    assign bo = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bo_bit;

    full_sub u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (brw),
        .d   (d_bit),
        .bo  (bo_bit)
    );

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    d_sr <= {d_bit, d_sr[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    brw  <= bo_bit;
                    // Counter stops at the last bit so it never wraps inside an op.
                    if (cnt == LAST) begin
                        diff  <= {d_bit, d_sr[WIDTH-1:1]};
                        bout  <= bo_bit;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized scoreboard bench for serial_sub_ctrl (WIDTH=8 and WIDTH=2 instances).
module tb_serial_sub_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] diff;
    logic       bout;

    logic       start2;
    logic [1:0] a2, b2;
    logic       busy2, done2;
    logic [1:0] diff2;
    logic       bout2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [7:0] hold_d = 8'd0;
    logic       hold_b = 1'b0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_sub_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference: plain unsigned arithmetic on the captured operands.
    function automatic logic [8:0] model8(input logic [7:0] av, input logic [7:0] bv);
        int unsigned dv;
        dv = (int'(av) - int'(bv) + 256) % 256;
        return {dv[7:0], (av < bv)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q8.size() == 0) begin
                chk("unexpected_done_w8", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("diff_w8", 32'(diff), 32'(e[8:1]));
                chk("bout_w8", 32'(bout), 32'(e[0]));
                hold_d = e[8:1];
                hold_b = e[0];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                chk("unexpected_done_w2", 32'd1, 32'd0);
            end else begin
                logic [2:0] e;
                e = q2.pop_front();
                chk("diff_w2", 32'(diff2), 32'(e[2:1]));
                chk("bout_w2", 32'(bout2), 32'(e[0]));
            end
        end
    end

    // One operation; optionally pulses start again at busy cycles 3 and 9.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input bit pulses);
        int k, dn, dpos;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        q8.push_back(model8(av, bv));
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        k = 0; dn = 0; dpos = 0;
        while (busy && k < 50) begin
            k++;
            if (done) begin dn++; dpos = k; end
            if (k == 4) begin
                chk("hold_diff", 32'(diff), 32'(hold_d));
                chk("hold_bout", 32'(bout), 32'(hold_b));
            end
            start = pulses && (k == 3 || k == 9);
            if (start) begin a = 8'($urandom); b = 8'($urandom); end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_len", k, 9);
        chk("done_count", dn, 1);
        chk("done_pos", dpos, 9);
    endtask

    task automatic op2(input logic [1:0] av, input logic [1:0] bv);
        int k;
        logic [1:0] dd;
        dd = av - bv;
        @(negedge clk);
        start2 = 1'b1; a2 = av; b2 = bv;
        q2.push_back({dd, (av < bv)});
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (busy2 && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("busy_len_w2", k, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] av, bv;
        int t_prev, t_now, k;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;

        // Reset with start toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = i[0]; a = 8'($urandom); b = 8'($urandom);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_diff", 32'(diff), 0);
            chk("rst_bout", 32'(bout), 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        do_op(8'd100, 8'd37, 1'b0);
        do_op(8'd5, 8'd9, 1'b0);
        do_op(8'd0, 8'hFF, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0);

        // Starts while busy are dropped
        do_op(8'd200, 8'd13, 1'b1);
        do_op(8'd7, 8'd250, 1'b1);
        repeat (12) @(negedge clk);
        chk("idle_after_ignored", 32'(busy), 0);

        for (int i = 0; i < 20; i++) do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // start held high: one op every WIDTH+2 cycles
        t_prev = -1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            a = av; b = bv;
            q8.push_back(model8(av, bv));
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 2) begin a = 8'($urandom); b = 8'($urandom); end
            end while (!done && k < 30);
            chk("b2b_done_seen", 32'(done), 1);
            t_now = cyc;
            if (t_prev >= 0) chk("b2b_spacing", t_now - t_prev, 10);
            t_prev = t_now;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-operation
        do_op(8'd5, 8'd9, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'($urandom); b = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_diff", 32'(diff), 0);
        chk("abort_bout", 32'(bout), 0);
        hold_d = 8'd0; hold_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_abort_diff", 32'(diff), 0);
        do_op(8'($urandom), 8'($urandom), 1'b0);
        do_op(8'd128, 8'd129, 1'b0);

        // Exhaustive WIDTH=2
        for (int i = 0; i < 16; i++) op2(2'(i >> 2), 2'(i));

        repeat (5) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
